// File: rtl/panda_pulse_pkg.sv
// Shared types and helpers for the panda pulse multiplier: FSM encoding,
// default counter width and the burst-parameter validity rule.
package panda_pulse_pkg;

    localparam int unsigned CW_DEFAULT = 32;
    localparam int unsigned MAX_CW     = 64;

    typedef logic [MAX_CW-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    // Callers zero-extend their CW-bit register values to word_t.
    function automatic logic valid_params(input word_t n, input word_t p, input word_t w);
        return (n >= word_t'(1)) && (p >= word_t'(2)) &&
               (w >= word_t'(1)) && (w <= p - word_t'(1));
    endfunction

endpackage

// File: rtl/panda_edge_detect.sv
// Registered-history rising-edge detector; RST_VAL sets the history value
// after reset so a level already high at release is not seen as an edge.
module panda_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    always_comb prev_d = sig_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) prev_q <= RST_VAL;
        else        prev_q <= prev_d;
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/panda_pulse_mult.sv
// Pulse multiplier: each rising edge on inp_i launches a burst of NPULSES
// pulses (WIDTH high, PERIOD repetition). Optional: PANDA_PULSE_MULT_TRIG_QUEUE_EN.
module panda_pulse_mult
    import panda_pulse_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inp_i,
    output logic          out_o,
    output logic          busy_o,
    input  logic [CW-1:0] NPULSES,
    input  logic [CW-1:0] PERIOD,
    input  logic [CW-1:0] WIDTH,
    input  logic          FORCE_RST,
    output logic [CW-1:0] MISSED,
    output logic          BAD_PARAM
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pulses_q, pulses_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] missed_q, missed_d;
    logic          bad_q, bad_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
    logic          pend_q, pend_d;
`endif
    logic          rise_w;
    logic          params_ok;
    logic          launch;

    panda_edge_detect #(.RST_VAL(1'b1)) u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (inp_i),
        .rise_o (rise_w)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulses_d  = pulses_q;
        period_d  = period_q;
        width_d   = width_q;
        missed_d  = missed_q;
        bad_d     = bad_q;
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
        pend_d    = pend_q;
`endif
        launch    = 1'b0;
        params_ok = valid_params(word_t'(NPULSES), word_t'(PERIOD), word_t'(WIDTH));

        if (FORCE_RST) begin
            state_d  = IDLE;
            missed_d = '0;
            bad_d    = 1'b0;
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
            pend_d   = 1'b0;
`endif
        end else begin
            // Busy-time edges are accounted before the phase logic so a
            // relaunch on the final LOW cycle can consume a pending flag.
            if (rise_w && state_q != IDLE) begin
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
                if (!pend_q)                 pend_d   = 1'b1;
                else if (missed_q != '1)     missed_d = missed_q + CW'(1);
`else
                if (missed_q != '1)          missed_d = missed_q + CW'(1);
`endif
            end

            unique case (state_q)
                IDLE: begin
                    if (rise_w) begin
                        if (params_ok) launch = 1'b1;
                        else           bad_d  = 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = LOW;
                        cnt_d   = period_q - width_q;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                LOW: begin
                    if (cnt_q != CW'(1)) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (pulses_q > CW'(1)) begin
                        state_d  = HIGH;
                        cnt_d    = width_q;
                        pulses_d = pulses_q - CW'(1);
                    end else begin
                        state_d = IDLE;
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
                        if (pend_q || rise_w) begin
                            pend_d = 1'b0;
                            if (params_ok) launch = 1'b1;
                            else           bad_d  = 1'b1;
                        end
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (launch) begin
            state_d  = HIGH;
            cnt_d    = WIDTH;
            pulses_d = NPULSES;
            period_d = PERIOD;
            width_d  = WIDTH;
        end

        out_d  = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pulses_q <= '0;
            period_q <= '0;
            width_q  <= '0;
            missed_q <= '0;
            bad_q    <= 1'b0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulses_q <= pulses_d;
            period_q <= period_d;
            width_q  <= width_d;
            missed_q <= missed_d;
            bad_q    <= bad_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
`ifdef PANDA_PULSE_MULT_TRIG_QUEUE_EN
            pend_q   <= pend_d;
`endif
        end
    end

    assign out_o     = out_q;
    assign busy_o    = busy_q;
    assign MISSED    = missed_q;
    assign BAD_PARAM = bad_q;

endmodule

// File: doc/panda_pulse_mult.md
Name: panda_pulse_mult

Overview:
- Pulse multiplier; complements panda_div.
- panda_div reduces an incoming pulse train. This block expands each trigger rising edge on inp_i into a programmed burst of NPULSES pulses with WIDTH-cycle high time and PERIOD-cycle repetition.
- Sits in the same position block fabric as panda_div. Register-style inputs and readbacks are uppercase, as in panda_div.

Parameters:
- CW, 32, width of NPULSES/PERIOD/WIDTH/MISSED and internal counters.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset (asserted at 0).
- inp_i  in  1  trigger input; rising edge starts a burst.
- out_o  out  1  burst pulse output, registered.
- busy_o  out  1  high while a burst is in progress.
- NPULSES  in  CW  pulses per burst.
- PERIOD  in  CW  pulse period in clocks.
- WIDTH  in  CW  pulse high time in clocks.
- FORCE_RST  in  1  synchronous soft reset, level-sensitive.
- MISSED  out  CW  triggers dropped while busy; saturating.
- BAD_PARAM  out  1  sticky flag: a trigger was rejected because of invalid parameters.

Behaviour:
- Reset (rst_i=0, async):
  - out_o=0, busy_o=0, MISSED=0, BAD_PARAM=0, state=IDLE.
  - Edge-detect history register = 1, so inp_i already high at reset release is not an edge.
- Edge detect: edge = inp_i & ~inp_prev; inp_prev is registered every cycle.
- Parameters are valid when NPULSES>=1, PERIOD>=2 and 1<=WIDTH<=PERIOD-1.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - Edge with valid parameters: latch NPULSES/PERIOD/WIDTH into shadow registers, load counters, go to HIGH.
  - Latency: out_o=1 and busy_o=1 on the cycle after the edge is sampled.
  - Edge with invalid parameters: stay in IDLE, set BAD_PARAM, no output.
- HIGH: out_o=1 for WIDTH cycles, then go to LOW.
- LOW:
  - out_o=0 for PERIOD-WIDTH cycles.
  - Then: pulses remaining >0 → HIGH; otherwise → IDLE with busy_o=0.
- Burst length: exactly NPULSES*PERIOD cycles of busy_o.
- Live parameter changes mid-burst are ignored; shadow registers only.
- Edge seen while busy (in HIGH or LOW, including the final LOW cycle): dropped, MISSED += 1.
  - MISSED saturates at 2^CW-1.
- Edge in the same cycle the FSM returns to IDLE (busy_o still 1) counts as missed.
- FORCE_RST=1:
  - Next cycle: state=IDLE, out_o=0, busy_o=0, MISSED=0, BAD_PARAM=0.
  - Edges are ignored while it is held.
  - A rising inp_i after FORCE_RST is released triggers normally.
- rst_i mid-burst: immediate async return to the reset values; no partial pulse is completed.
- Counter arithmetic:
  - Unsigned, CW bits, down-counting to 1.
  - No wrap is possible because parameters are validated at latch time.

Optional Feature:
- Macro: PANDA_PULSE_MULT_TRIG_QUEUE_EN.
- When defined:
  - One-deep pending-trigger flag.
  - The first edge during a burst sets the flag instead of incrementing MISSED.
  - On burst end the FSM goes straight to HIGH with freshly latched parameters; busy_o stays 1, with no IDLE cycle.
  - Further edges while the flag is set increment MISSED.
  - If the parameters are invalid at relaunch: set BAD_PARAM, clear the flag, go to IDLE.
  - FORCE_RST and rst_i clear the flag.
- When undefined: there is no flag, and every busy-time edge increments MISSED.

Decomposition:
- Shared package panda_pulse_pkg:
  - FSM state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2).
  - Default CW.
  - Parameter-validity function, also reused by the bench model.
- One natural sub-module: panda_edge_detect (rising-edge detector with a reset-value parameter for the history register). It is shared with other position blocks.

Test Plan:
- Basic burst: NPULSES=3, PERIOD=5, WIDTH=2; inp_i edge sampled at cycle T →
  - out_o high T+1..T+2, T+6..T+7 and T+11..T+12, low otherwise.
  - busy_o high T+1..T+15; MISSED=0.
- Retrigger while busy: same parameters, second edge at T+8 → burst unchanged, MISSED=1. With TRIG_QUEUE_EN: MISSED=0, second burst starts at T+16, busy_o continuously high T+1..T+30.
- Invalid parameters: WIDTH=5, PERIOD=5, edge → out_o stays 0, busy_o 0, BAD_PARAM=1. WIDTH=0 and NPULSES=0 behave the same way.
- Mid-burst parameter change: NPULSES=2, PERIOD=4, WIDTH=1; set PERIOD=10 at T+2 → pulses at T+1 and T+5 only; busy_o low from T+9.
- FORCE_RST mid-burst: pulse at FORCE_RST=1 during the HIGH phase → out_o=0 and busy_o=0 the next cycle, MISSED=0; a fresh edge after release gives a full burst.
- Async reset: rst_i=0 mid-burst with inp_i held high, then released → all outputs 0, and no burst until inp_i falls and rises again.
